mux41_rr_arbiter: RTL and testbench
===================================

# mux41_rr_arbiter

Round-robin arbiter that shares one 1-bit mux output channel among four requesters. It grants exactly one requester at a time and drives the 2-bit select of a 4:1 mux built from `mux21_gate` cells. The selected requester's data bit is forwarded to `y`. It sits in front of the mux datapath and is the only block allowed to drive its select lines.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per requester; only used when `MUX_ARB_TIMEOUT_EN` is defined. Legal range 2..15.
- `CNT_W`, default 4: hold-counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- `clk`  input  1  single clock, rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req`  input  4  request per requester; bit i belongs to requester i.
- `d`  input  4  data bit per requester.
- `gnt`  output  4  one-hot grant, registered; all zeros when idle.
- `sel`  output  2  mux select, registered; index of the granted requester.
- `y`  output  1  forwarded data: `d[sel]` when `busy`=1, else 0.
- `busy`  output  1  high while a grant is held (state OWN).

## Operation
- FSM has two states, IDLE and OWN.
- Round-robin pointer `ptr` (2 bits) names the highest-priority requester. Priority order is ptr, ptr+1, ptr+2, ptr+3, mod 4.
- **IDLE:**
  - If `req` is nonzero, select the first set bit in priority order. Load `sel` with that index and `gnt` with the matching one-hot value. Clear the hold counter to 1. Go to OWN.
  - If `req` is 0, stay in IDLE with outputs unchanged at zero.
- **OWN:**
  - If `req[sel]` is 0, release the grant.
  - Otherwise stay in OWN and increment the hold counter (saturating).
- **Release:**
  - `gnt` goes to 0 and `busy` goes to 0.
  - `ptr` becomes sel+1 mod 4.
  - FSM returns to IDLE.
  - `sel` holds its last value; it is don't-care while idle.
- Requests from other requesters during OWN are ignored; they do not pre-empt.
- Only the `req` bit of the granted index matters in OWN. Changes to other `req` bits take effect at the next IDLE evaluation.
- `y` is combinational: `busy & d[sel]`. No latency from `d` to `y`.
- Reset values: `gnt`=0, `sel`=0, `busy`=0, `y`=0, `ptr`=0, hold counter=0, state=IDLE.
- Reset asserted mid-grant forces all of the above immediately, without waiting for a clock edge.

## Timing
- Request to grant: `req` sampled high at edge N → `gnt`/`busy` high after edge N. The first cycle in which `y` reflects `d[sel]` is the cycle following edge N.
- Release: `req[sel]` sampled low at edge M → `gnt` is 0 after edge M.
- There is always at least one IDLE cycle between consecutive grants (one bubble). A requester that re-raises `req` immediately competes at the lowest priority.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins. After reset, requester 0 wins first.
- A single-cycle `req` pulse yields a grant lasting exactly one cycle: granted at edge N, then `req` is sampled low at edge N+1, releasing the grant.

## Configuration
- Macro: `MUX_ARB_TIMEOUT_EN`.
- **Defined:**
  - In OWN, when the hold counter equals `MAX_HOLD` at an edge, release the grant even if `req[sel]` is still 1.
  - The grant is therefore held for at most `MAX_HOLD` cycles.
  - The released requester moves to lowest priority. If it still requests and others are idle, it is re-granted after the one-cycle bubble.
- **Undefined:**
  - No timeout; the grant is held until `req[sel]` drops.
  - The hold counter and `MAX_HOLD` logic are not compiled in.

## Test plan
- **Reset:** assert `rst_n`=0 mid-grant → `gnt`=0000, `busy`=0, `y`=0 immediately, with no clock edge; after release, requester 0 wins first.
- **Single requester:** `req`=0100 held 5 cycles, `d[2]` toggling → `gnt`=0100 and `sel`=2 from the next edge; `y` follows `d[2]` for 5 cycles; `gnt`=0000 one edge after `req` drops.
- **All request from reset:** `req`=1111 held, each requester drops `req` 3 cycles after its grant (macro off) → grant order 0,1,2,3,0 with one idle cycle between grants.
- **No pre-emption:** requester 3 granted, then `req`=1001 raised → `gnt` stays 1000 until `req[3]` drops; next grant goes to 0.
- **Timeout (macro on, MAX_HOLD=8):** `req`=0011 held continuously → `gnt`=0001 for exactly 8 cycles, one idle cycle, `gnt`=0010 for 8 cycles, then alternating.
- **Macro off, same stimulus as timeout test:** `gnt`=0001 persists indefinitely (checked over 50 cycles).

Source files
------------

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing a 1-bit 4:1 mux channel among four requesters.
// Optional grant timeout is compiled in with `define MUX_ARB_TIMEOUT_EN.

module mux21_gate (
  input  logic a,
  input  logic b,
  input  logic s,
  output logic y
);
  assign y = (a & ~s) | (b & s);
endmodule

module mux41_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic [3:0] d,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       y,
  output logic       busy
);

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // Reject configurations where the hold counter could never reach MAX_HOLD.
  if (MAX_HOLD < 2 || MAX_HOLD > 15 || (1 << CNT_W) <= MAX_HOLD) begin : g_param_check
    $error("mux41_rr_arbiter: illegal MAX_HOLD/CNT_W combination");
  end

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] rot_req;
  logic [1:0] win_off;
  logic [1:0] win_idx;
  logic       release_grant;
  logic [1:0] mux_lvl1;
  logic       mux_out;

`ifdef MUX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_reg, cnt_next;
`endif

  // rot_req[0] is the requester currently at highest priority (ptr).
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot_req[gi] = req[ptr_reg + 2'(gi)];
  end

  always_comb begin
    win_off = 2'd0;
    casez (rot_req)
      4'b???1: win_off = 2'd0;
      4'b??10: win_off = 2'd1;
      4'b?100: win_off = 2'd2;
      4'b1000: win_off = 2'd3;
      default: win_off = 2'd0;
    endcase
  end

  assign win_idx = ptr_reg + win_off;

`ifdef MUX_ARB_TIMEOUT_EN
  assign release_grant = ~req[sel_reg] | (cnt_reg == CNT_W'(MAX_HOLD));
`else
  assign release_grant = ~req[sel_reg];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'd0;
      ptr_reg   <= 2'd0;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_reg   <= '0;
`endif
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
`ifdef MUX_ARB_TIMEOUT_EN
      cnt_reg   <= cnt_next;
`endif
    end
  end

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
`ifdef MUX_ARB_TIMEOUT_EN
    cnt_next   = cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (|req) begin
          sel_next   = win_idx;
          gnt_next   = 4'b0001 << win_idx;
          state_next = OWN;
`ifdef MUX_ARB_TIMEOUT_EN
          cnt_next   = CNT_W'(1);
`endif
        end
      end
      OWN: begin
        // sel is left alone on release so the mux select does not glitch.
        if (release_grant) begin
          gnt_next   = 4'b0000;
          ptr_next   = sel_reg + 2'd1;
          state_next = IDLE;
        end else begin
`ifdef MUX_ARB_TIMEOUT_EN
          if (cnt_reg != '1) begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase
  end

  // Two-level mux tree: bit 0 of sel picks within each pair, bit 1 picks the pair.
  for (genvar gi = 0; gi < 2; gi++) begin : g_mux_lvl1
    mux21_gate u_mux (
      .a (d[2*gi]),
      .b (d[2*gi+1]),
      .s (sel_reg[0]),
      .y (mux_lvl1[gi])
    );
  end

  mux21_gate u_mux_lvl2 (
    .a (mux_lvl1[0]),
    .b (mux_lvl1[1]),
    .s (sel_reg[1]),
    .y (mux_out)
  );

  assign gnt  = gnt_reg;
  assign sel  = sel_reg;
  assign busy = (state_reg == OWN);
  assign y    = busy & mux_out;

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Self-checking bench for mux41_rr_arbiter: per-cycle scoreboard against a
// behavioural model plus directed checks of grant order, bubbles and reset.

module tb_mux41_rr_arbiter;

  localparam int MAX_HOLD = 8;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TIMEOUT = 1'b1;
`else
  localparam bit TIMEOUT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       y;
  logic       busy;

  mux41_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .d     (d),
    .gnt   (gnt),
    .sel   (sel),
    .y     (y),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       y;
  } exp_t;

  exp_t       exp_q[$];
  logic [1:0] grant_log[$];
  int         checks = 0;
  int         passes = 0;
  int         step_no = 0;
  int         hold = 0;
  logic       prev_busy = 1'b0;

  // Reference model state
  logic       m_busy = 1'b0;
  logic [1:0] m_sel = 2'd0;
  logic [1:0] m_ptr = 2'd0;
  int         m_cnt = 0;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
  endtask

  task automatic model_reset();
    m_busy = 1'b0;
    m_sel  = 2'd0;
    m_ptr  = 2'd0;
    m_cnt  = 0;
  endtask

  // Advance the model by one clock edge with the given request vector.
  task automatic model_edge(input logic [3:0] r);
    logic       found;
    logic [1:0] idx;
    if (!m_busy) begin
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
        idx = m_ptr + 2'(k);
        if (!found && r[idx]) begin
          found  = 1'b1;
          m_sel  = idx;
          m_busy = 1'b1;
          m_cnt  = 1;
        end
      end
    end else if (!r[m_sel] || (TIMEOUT && m_cnt == MAX_HOLD)) begin
      m_busy = 1'b0;
      m_ptr  = m_sel + 2'd1;
    end else if (m_cnt < 15) begin
      m_cnt++;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] dv);
    exp_t e;
    req = r;
    d   = dv;
    model_edge(r);
    e.gnt  = m_busy ? (4'b0001 << m_sel) : 4'b0000;
    e.sel  = m_sel;
    e.busy = m_busy;
    e.y    = m_busy & dv[m_sel];
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("gnt", gnt, e.gnt);
    chk("sel", {2'b00, sel}, {2'b00, e.sel});
    chk("busy", {3'b000, busy}, {3'b000, e.busy});
    chk("y", {3'b000, y}, {3'b000, e.y});
    if (busy && !prev_busy) grant_log.push_back(sel);
    hold      = busy ? hold + 1 : 0;
    prev_busy = busy;
    $display("step %0d req=%b d=%b gnt=%b sel=%0d busy=%b y=%b",
             step_no, r, dv, gnt, sel, busy, y);
    step_no++;
  endtask

  // Asserts reset away from the clock edge and checks it acts without an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_async_gnt", gnt, 4'b0000);
    chk("rst_async_busy", {3'b000, busy}, 4'b0000);
    chk("rst_async_y", {3'b000, y}, 4'b0000);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_sel", {2'b00, sel}, 4'b0000);
    rst_n     = 1'b1;
    prev_busy = 1'b0;
    hold      = 0;
  endtask

  initial begin
    logic [3:0] r;
    logic [1:0] exp_order[5];
    logic [1:0] exp_alt[4];
    exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_alt   = '{2'd0, 2'd1, 2'd0, 2'd1};

    rst_n = 1'b0;
    req   = 4'b0000;
    d     = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", gnt, 4'b0000);
    chk("reset_sel", {2'b00, sel}, 4'b0000);
    chk("reset_busy", {3'b000, busy}, 4'b0000);
    chk("reset_y", {3'b000, y}, 4'b0000);
    rst_n = 1'b1;

    step(4'b0000, 4'b1111);
    step(4'b0000, 4'b0000);

    // All four request; each drops its request after 3 grant cycles.
    grant_log.delete();
    for (int i = 0; i < 40 && grant_log.size() < 5; i++) begin
      r = 4'b1111;
      if (busy && hold >= 3) r[sel] = 1'b0;
      step(r, 4'($urandom));
    end
    for (int k = 0; k < 5; k++) chk("rr_order", {2'b00, grant_log[k]}, {2'b00, exp_order[k]});
    step(4'b0000, 4'b0000);

    // Single requester 2 held 5 cycles with toggling data.
    step(4'b0100, 4'b0100);
    chk("single_gnt", gnt, 4'b0100);
    chk("single_sel", {2'b00, sel}, 4'b0010);
    d = 4'b1011;
    #1;
    chk("single_y_comb", {3'b000, y}, 4'b0000);
    for (int i = 0; i < 4; i++) step(4'b0100, (i % 2 == 0) ? 4'b0000 : 4'b0100);
    step(4'b0000, 4'b0100);
    chk("single_release", gnt, 4'b0000);

    // No pre-emption: requester 3 keeps the grant while 0 waits.
    step(4'b1000, 4'b1000);
    chk("nopre_first", gnt, 4'b1000);
    for (int i = 0; i < 3; i++) begin
      step(4'b1001, 4'($urandom));
      chk("nopre_hold", gnt, 4'b1000);
    end
    step(4'b0001, 4'b0001);
    chk("nopre_bubble", gnt, 4'b0000);
    step(4'b0001, 4'b0001);
    chk("nopre_next", gnt, 4'b0001);
    step(4'b0000, 4'b0000);

    // Reset during a grant, then requester 0 must win first.
    step(4'b0010, 4'b1111);
    chk("mid_grant_y", {3'b000, y}, 4'b0001);
    do_reset();
    step(4'b1111, 4'b0000);
    chk("post_reset_winner", gnt, 4'b0001);
    step(4'b0000, 4'b0000);

    // Continuous req=0011 from a fresh reset.
    do_reset();
    grant_log.delete();
    for (int i = 0; i < 50; i++) begin
      step(4'b0011, 4'($urandom));
`ifdef MUX_ARB_TIMEOUT_EN
      if (i == 7) chk("timeout_last_cycle", gnt, 4'b0001);
      if (i == 8) chk("timeout_bubble", gnt, 4'b0000);
      if (i == 9) chk("timeout_next", gnt, 4'b0010);
`else
      chk("no_timeout_hold", gnt, 4'b0001);
`endif
    end
`ifdef MUX_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) chk("timeout_alt", {2'b00, grant_log[k]}, {2'b00, exp_alt[k]});
`endif
    step(4'b0000, 4'b0000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
